// File: rtl/axi_cpu_arbiter_pkg.sv
// Shared AXI channel payloads, arbiter FSM state types and a sizing helper
// for the CPU-to-memory funnel.
package axi_cpu_arbiter_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } axi_aw_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } axi_w_t;

   typedef struct packed {
      logic [1:0] resp;
   } axi_b_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } axi_ar_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } axi_r_t;

   typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_e;
   typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;

   // Index width never drops below one bit so a single-port build still has a grant register.
   function automatic int idx_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_cpu_arbiter_if.sv
// Single-beat AXI bundle carrying N parallel ports; N=CPU_NB on the CPU side,
// N=1 on the memory side.
interface axi_cpu_arbiter_if #(parameter int N = 1);
   import axi_cpu_arbiter_pkg::*;

   axi_aw_t [N-1:0] aw;
   logic    [N-1:0] awvalid;
   logic    [N-1:0] awready;
   axi_w_t  [N-1:0] w;
   logic    [N-1:0] wvalid;
   logic    [N-1:0] wready;
   axi_b_t  [N-1:0] b;
   logic    [N-1:0] bvalid;
   logic    [N-1:0] bready;
   axi_ar_t [N-1:0] ar;
   logic    [N-1:0] arvalid;
   logic    [N-1:0] arready;
   axi_r_t  [N-1:0] r;
   logic    [N-1:0] rvalid;
   logic    [N-1:0] rready;

   modport master (
      output aw, awvalid, w, wvalid, bready, ar, arvalid, rready,
      input  awready, wready, b, bvalid, arready, r, rvalid
   );

   modport slave (
      input  aw, awvalid, w, wvalid, bready, ar, arvalid, rready,
      output awready, wready, b, bvalid, arready, r, rvalid
   );
endinterface

// File: rtl/axi_cpu_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping
// at N.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] grant,
   output logic             any_req
);

   logic [IDX_W:0] cand;
   logic           found;

   // ptr < N, so one conditional subtract is enough to wrap the candidate.
   always_comb begin
      grant = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
         if (!found && req[cand[IDX_W-1:0]]) begin
            grant = cand[IDX_W-1:0];
            found = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/axi_cpu_arbiter.sv
// N-to-1 single-beat AXI funnel: independent round-robin write (AW/W/B) and
// read (AR/R) paths, grant held from arbitration until the response handshake.
module axi_cpu_arbiter
   import axi_cpu_arbiter_pkg::*;
#(
   parameter int CPU_NB = 4
) (
   input  logic              clk,
   input  logic              rst,
   axi_cpu_arbiter_if.slave  cpu,
   axi_cpu_arbiter_if.master mem
);

   localparam int IDX_W = idx_w(CPU_NB);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(CPU_NB - 1);

   wr_state_e        wr_state;
   rd_state_e        rd_state;
   logic [IDX_W-1:0] wgrant, wptr, wsel;
   logic [IDX_W-1:0] rgrant, rptr, rsel;
   logic             wany, rany;

   rr_arbiter #(.N(CPU_NB), .IDX_W(IDX_W)) u_wr_arb (
      .req(cpu.awvalid), .ptr(wptr), .grant(wsel), .any_req(wany));

   rr_arbiter #(.N(CPU_NB), .IDX_W(IDX_W)) u_rd_arb (
      .req(cpu.arvalid), .ptr(rptr), .grant(rsel), .any_req(rany));

   // Arbitration is registered: IDLE only latches the pick, nothing is forwarded yet.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= WR_IDLE;
         wgrant   <= '0;
         wptr     <= '0;
      end else begin
         case (wr_state)
            WR_IDLE: if (wany) begin
               wgrant   <= wsel;
               wr_state <= WR_AW;
            end
            WR_AW: if (mem.awvalid[0] && mem.awready[0]) wr_state <= WR_W;
            WR_W:  if (mem.wvalid[0] && mem.wready[0]) wr_state <= WR_B;
            WR_B:  if (mem.bvalid[0] && mem.bready[0]) begin
               wptr     <= (wgrant == LAST) ? '0 : wgrant + 1'b1;
               wr_state <= WR_IDLE;
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state <= RD_IDLE;
         rgrant   <= '0;
         rptr     <= '0;
      end else begin
         case (rd_state)
            RD_IDLE: if (rany) begin
               rgrant   <= rsel;
               rd_state <= RD_AR;
            end
            RD_AR: if (mem.arvalid[0] && mem.arready[0]) rd_state <= RD_R;
            RD_R:  if (mem.rvalid[0] && mem.rready[0]) begin
               rptr     <= (rgrant == LAST) ? '0 : rgrant + 1'b1;
               rd_state <= RD_IDLE;
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   // Only the granted port ever sees a ready or valid; everything else stays zero.
   always_comb begin
      mem.aw      = '0;
      mem.awvalid = '0;
      mem.w       = '0;
      mem.wvalid  = '0;
      mem.bready  = '0;
      cpu.awready = '0;
      cpu.wready  = '0;
      cpu.b       = '0;
      cpu.bvalid  = '0;
      case (wr_state)
         WR_AW: begin
            mem.aw[0]           = cpu.aw[wgrant];
            mem.awvalid[0]      = cpu.awvalid[wgrant];
            cpu.awready[wgrant] = mem.awready[0];
         end
         WR_W: begin
            mem.w[0]           = cpu.w[wgrant];
            mem.wvalid[0]      = cpu.wvalid[wgrant];
            cpu.wready[wgrant] = mem.wready[0];
         end
         WR_B: begin
            cpu.b[wgrant]      = mem.b[0];
            cpu.bvalid[wgrant] = mem.bvalid[0];
            mem.bready[0]      = cpu.bready[wgrant];
         end
         default: ;
      endcase
   end

   always_comb begin
      mem.ar      = '0;
      mem.arvalid = '0;
      mem.rready  = '0;
      cpu.arready = '0;
      cpu.r       = '0;
      cpu.rvalid  = '0;
      case (rd_state)
         RD_AR: begin
            mem.ar[0]           = cpu.ar[rgrant];
            mem.arvalid[0]      = cpu.arvalid[rgrant];
            cpu.arready[rgrant] = mem.arready[0];
         end
         RD_R: begin
            cpu.r[rgrant]      = mem.r[0];
            cpu.rvalid[rgrant] = mem.rvalid[0];
            mem.rready[0]      = cpu.rready[rgrant];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_cpu_arbiter.sv
// Randomized bench for axi_cpu_arbiter: CPU/memory drivers plus a
// transaction-level round-robin model checked every cycle.
module tb_axi_cpu_arbiter;
   import axi_cpu_arbiter_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_cpu_arbiter_if #(.N(N)) cpu_if ();
   axi_cpu_arbiter_if #(.N(1)) mem_if ();

   axi_cpu_arbiter #(.CPU_NB(N)) dut (.clk(clk), .rst(rst), .cpu(cpu_if), .mem(mem_if));

   int total = 0, bad = 0, cyc = 0;

   // bench drivers
   int wr_left[N], rd_left[N], wst[N], wdone[N], rst_[N], rdone[N];
   bit wr_act[N], rd_act[N];
   bit rnd_cpu = 0, w_block = 0;
   int wait_pct = 0, b_cfg = 0, rst_left = 0;
   bit m_b_pend, m_r_pend;
   int m_b_dly, m_r_dly, aw_stall;
   axi_b_t m_b_val;
   axi_r_t m_r_val;
   int wlog[$], rlog[$];

   // sampled handshakes, applied after the next edge
   logic [N-1:0] hs_aw, hs_w, hs_b, hs_ar, hs_r;
   bit hs_mw, hs_mb, hs_mar, hs_mr, seen_awv;
   logic [31:0] cap_ar_addr;

   // model: one transaction per path, stage 1=address, 2=data, 3=response
   bit w_busy = 0, r_busy = 0;
   int w_g, w_stage, w_ptr = 0, r_g, r_stage, r_ptr = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic int pick(logic [N-1:0] req, int ptr);
      for (int k = 0; k < N; k++) begin
         int j = (ptr + k) % N;
         if (req[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_check();
      logic [N-1:0] e_awr, e_wr, e_bv, e_arr, e_rv;
      axi_b_t [N-1:0] e_b;
      axi_r_t [N-1:0] e_r;
      logic e_mawv, e_mwv, e_mbr, e_marv, e_mrr;
      e_awr = '0; e_wr = '0; e_bv = '0; e_arr = '0; e_rv = '0;
      e_b = '0; e_r = '0;
      e_mawv = 0; e_mwv = 0; e_mbr = 0; e_marv = 0; e_mrr = 0;
      if (w_busy) begin
         if (w_stage == 1) begin
            e_mawv = cpu_if.awvalid[w_g];
            e_awr[w_g] = mem_if.awready[0];
            check("m_aw", 64'(mem_if.aw[0]), 64'(cpu_if.aw[w_g]));
         end else if (w_stage == 2) begin
            e_mwv = cpu_if.wvalid[w_g];
            e_wr[w_g] = mem_if.wready[0];
            check("m_w", 64'(mem_if.w[0]), 64'(cpu_if.w[w_g]));
         end else begin
            e_bv[w_g] = mem_if.bvalid[0];
            e_b[w_g] = mem_if.b[0];
            e_mbr = cpu_if.bready[w_g];
         end
      end
      if (r_busy) begin
         if (r_stage == 1) begin
            e_marv = cpu_if.arvalid[r_g];
            e_arr[r_g] = mem_if.arready[0];
            check("m_ar", 64'(mem_if.ar[0]), 64'(cpu_if.ar[r_g]));
         end else begin
            e_rv[r_g] = mem_if.rvalid[0];
            e_r[r_g] = mem_if.r[0];
            e_mrr = cpu_if.rready[r_g];
         end
      end
      check("wr_ctl", 64'({cpu_if.awready, cpu_if.wready, cpu_if.bvalid,
                           mem_if.awvalid, mem_if.wvalid, mem_if.bready}),
                      64'({e_awr, e_wr, e_bv, e_mawv, e_mwv, e_mbr}));
      check("rd_ctl", 64'({cpu_if.arready, cpu_if.rvalid, mem_if.arvalid, mem_if.rready}),
                      64'({e_arr, e_rv, e_marv, e_mrr}));
      check("s_b", 64'(cpu_if.b), 64'(e_b));
      check("s_r", 64'(cpu_if.r[0]) ^ 64'(cpu_if.r[1]) << 1 ^ 64'(cpu_if.r[2]) << 2 ^ 64'(cpu_if.r[3]) << 3,
                   64'(e_r[0]) ^ 64'(e_r[1]) << 1 ^ 64'(e_r[2]) << 2 ^ 64'(e_r[3]) << 3);
   endtask

   task automatic model_update();
      if (rst) begin
         w_busy = 0; w_ptr = 0; r_busy = 0; r_ptr = 0;
      end else begin
         if (!w_busy) begin
            if (|cpu_if.awvalid) begin
               w_g = pick(cpu_if.awvalid, w_ptr); w_busy = 1; w_stage = 1;
            end
         end else if (w_stage == 1) begin
            if (cpu_if.awvalid[w_g] && mem_if.awready[0]) w_stage = 2;
         end else if (w_stage == 2) begin
            if (cpu_if.wvalid[w_g] && mem_if.wready[0]) w_stage = 3;
         end else if (mem_if.bvalid[0] && cpu_if.bready[w_g]) begin
            w_busy = 0; w_ptr = (w_g + 1) % N;
         end
         if (!r_busy) begin
            if (|cpu_if.arvalid) begin
               r_g = pick(cpu_if.arvalid, r_ptr); r_busy = 1; r_stage = 1;
            end
         end else if (r_stage == 1) begin
            if (cpu_if.arvalid[r_g] && mem_if.arready[0]) r_stage = 2;
         end else if (mem_if.rvalid[0] && cpu_if.rready[r_g]) begin
            r_busy = 0; r_ptr = (r_g + 1) % N;
         end
      end
   endtask

   task automatic clear_bench();
      cpu_if.aw = '0; cpu_if.awvalid = '0; cpu_if.w = '0; cpu_if.wvalid = '0;
      cpu_if.bready = '0; cpu_if.ar = '0; cpu_if.arvalid = '0; cpu_if.rready = '0;
      mem_if.awready = '0; mem_if.wready = '0; mem_if.b = '0; mem_if.bvalid = '0;
      mem_if.arready = '0; mem_if.r = '0; mem_if.rvalid = '0;
      for (int i = 0; i < N; i++) begin
         wr_act[i] = 0; rd_act[i] = 0; wr_left[i] = 0; rd_left[i] = 0;
      end
      m_b_pend = 0; m_r_pend = 0; m_b_dly = 0; m_r_dly = 0; aw_stall = 0;
   endtask

   task automatic apply_and_drive();
      for (int i = 0; i < N; i++) begin
         if (hs_aw[i]) cpu_if.awvalid[i] = 1'b0;
         if (hs_w[i]) cpu_if.wvalid[i] = 1'b0;
         if (hs_b[i]) begin wr_act[i] = 0; wr_left[i]--; wlog.push_back(i); wdone[i] = cyc - 1; end
         if (hs_ar[i]) cpu_if.arvalid[i] = 1'b0;
         if (hs_r[i]) begin rd_act[i] = 0; rd_left[i]--; rlog.push_back(i); rdone[i] = cyc - 1; end
      end
      if (m_b_pend && m_b_dly > 0) m_b_dly--;
      if (hs_mb) m_b_pend = 0;
      if (hs_mw) begin
         m_b_pend = 1; m_b_dly = (b_cfg < 0) ? int'($urandom_range(3)) : b_cfg;
         m_b_val.resp = 2'($urandom);
      end
      if (seen_awv && aw_stall > 0) aw_stall--;
      if (m_r_pend && m_r_dly > 0) m_r_dly--;
      if (hs_mr) m_r_pend = 0;
      if (hs_mar) begin
         m_r_pend = 1; m_r_dly = (b_cfg < 0) ? int'($urandom_range(3)) : 0;
         m_r_val.data = cap_ar_addr ^ 32'hDEAD_0000; m_r_val.resp = 2'($urandom);
      end
      for (int i = 0; i < N; i++) begin
         if (!wr_act[i] && wr_left[i] > 0 && (!rnd_cpu || $urandom_range(3) == 0)) begin
            wr_act[i] = 1; wst[i] = cyc;
            cpu_if.awvalid[i] = 1'b1; cpu_if.wvalid[i] = 1'b1;
            cpu_if.aw[i].addr = rnd_cpu ? $urandom : 32'h100;
            cpu_if.aw[i].prot = 3'($urandom);
            cpu_if.w[i].data  = rnd_cpu ? $urandom : 32'hA5;
            cpu_if.w[i].strb  = 4'hF;
         end
         if (!rd_act[i] && rd_left[i] > 0 && (!rnd_cpu || $urandom_range(3) == 0)) begin
            rd_act[i] = 1; rst_[i] = cyc;
            cpu_if.arvalid[i] = 1'b1;
            cpu_if.ar[i].addr = rnd_cpu ? $urandom : 32'h200 + 32'(i * 4);
            cpu_if.ar[i].prot = 3'($urandom);
         end
         cpu_if.bready[i] = !rnd_cpu || $urandom_range(2) != 0;
         cpu_if.rready[i] = !rnd_cpu || $urandom_range(2) != 0;
      end
      mem_if.awready[0] = aw_stall == 0 && $urandom_range(99) >= wait_pct;
      mem_if.wready[0]  = !w_block && $urandom_range(99) >= wait_pct;
      mem_if.arready[0] = $urandom_range(99) >= wait_pct;
      mem_if.bvalid[0]  = m_b_pend && m_b_dly == 0;
      mem_if.b[0]       = m_b_val;
      mem_if.rvalid[0]  = m_r_pend && m_r_dly == 0;
      mem_if.r[0]       = m_r_val;
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
      hs_aw = cpu_if.awvalid & cpu_if.awready;
      hs_w  = cpu_if.wvalid & cpu_if.wready;
      hs_b  = cpu_if.bvalid & cpu_if.bready;
      hs_ar = cpu_if.arvalid & cpu_if.arready;
      hs_r  = cpu_if.rvalid & cpu_if.rready;
      hs_mw  = mem_if.wvalid[0] && mem_if.wready[0];
      hs_mb  = mem_if.bvalid[0] && mem_if.bready[0];
      hs_mar = mem_if.arvalid[0] && mem_if.arready[0];
      hs_mr  = mem_if.rvalid[0] && mem_if.rready[0];
      seen_awv = mem_if.awvalid[0] && !mem_if.awready[0];
      cap_ar_addr = mem_if.ar[0].addr;
      model_update();
      @(posedge clk); #1;
      cyc++;
      if (rst_left > 0) begin
         rst = 1'b1; rst_left--; clear_bench();
      end else begin
         rst = 1'b0;
         apply_and_drive();
      end
   endtask

   function automatic bit all_idle();
      for (int i = 0; i < N; i++)
         if (wr_left[i] != 0 || rd_left[i] != 0 || wr_act[i] || rd_act[i]) return 0;
      return !w_busy && !r_busy && rst_left == 0;
   endfunction

   task automatic run_idle(string name, int max);
      int n = 0;
      while (!all_idle() && n < max) begin cycle(); n++; end
      if (!all_idle()) check({name, "_timeout"}, 64'(n), 64'(-1));
   endtask

   function automatic int lg(int q[$], int k);
      return (k < q.size()) ? q[k] : -1;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=hang want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_bench();
      rst = 1'b1;
      rst_left = 2;
      @(posedge clk); #1;
      repeat (3) cycle();

      // lone write from CPU2, zero-wait memory
      wr_left[2] = 1; wlog.delete();
      run_idle("t1", 50);
      check("t1_size", 64'(wlog.size()), 64'd1);
      check("t1_gnt", 64'(lg(wlog, 0)), 64'd2);
      check("t1_lat", 64'(wdone[2] - wst[2]), 64'd3);

      // wrap: pointer sits at 3, CPU3 and CPU0 request together
      wr_left[3] = 1; wr_left[0] = 1; wlog.delete();
      run_idle("t2", 50);
      check("t2_first", 64'(lg(wlog, 0)), 64'd3);
      check("t2_second", 64'(lg(wlog, 1)), 64'd0);

      // all four CPUs read at once
      for (int i = 0; i < N; i++) rd_left[i] = 1;
      rlog.delete();
      run_idle("t3", 80);
      for (int i = 0; i < N; i++) check("t3_order", 64'(lg(rlog, i)), 64'(i));
      check("t3_lat0", 64'(rdone[0] - rst_[0]), 64'd2);

      // concurrent write from CPU1 and read from CPU3
      wr_left[1] = 1; rd_left[3] = 1; wlog.delete(); rlog.delete();
      run_idle("t4", 50);
      check("t4_wgnt", 64'(lg(wlog, 0)), 64'd1);
      check("t4_rgnt", 64'(lg(rlog, 0)), 64'd3);
      check("t4_skew", 64'(wdone[1] - rdone[3]), 64'd1);

      // memory stalls AW 5 cycles and delays B 3 cycles
      aw_stall = 5; b_cfg = 3; wr_left[0] = 1; wr_left[1] = 1; wlog.delete();
      run_idle("t5", 100);
      check("t5_first", 64'(lg(wlog, 0)), 64'd0);
      check("t5_second", 64'(lg(wlog, 1)), 64'd1);
      check("t5_lat", 64'(wdone[0] - wst[0]), 64'd11);
      b_cfg = 0;

      // reset while the write sits in its data phase
      w_block = 1; wr_left[2] = 1;
      for (int n = 0; n < 20 && !(w_busy && w_stage == 2); n++) cycle();
      check("t6_reach_w", 64'(w_busy && w_stage == 2), 64'd1);
      cycle();
      rst_left = 2;
      repeat (4) cycle();
      w_block = 0;
      wr_left[1] = 1; wr_left[3] = 1; wlog.delete();
      run_idle("t6", 50);
      check("t6_first", 64'(lg(wlog, 0)), 64'd1);
      check("t6_second", 64'(lg(wlog, 1)), 64'd3);

      // randomized traffic on both paths with random memory waits
      rnd_cpu = 1; wait_pct = 30; b_cfg = -1;
      for (int i = 0; i < N; i++) begin wr_left[i] = 15; rd_left[i] = 15; end
      wlog.delete(); rlog.delete();
      run_idle("t7", 6000);
      check("t7_wcount", 64'(wlog.size()), 64'd60);
      check("t7_rcount", 64'(rlog.size()), 64'd60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
